// File: rtl/sevenseg_scan_pwm.sv
// Multi-digit seven-segment scanner with per-digit blanking, PWM brightness and frame strobe.
// Optional anti-ghosting guard interval enabled by defining SEVENSEG_GHOST_GUARD_EN.
module sevenseg_scan_pwm #(
  parameter int unsigned N              = 4,
  parameter int unsigned BRIGHT_W       = 4,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1,
  parameter int unsigned GUARD_CYCLES   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [7:0]          digit_values [0:N-1],
  input  logic [N-1:0]        blank,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [7:0]          seg_out,
  output logic [N-1:0]        an,
  output logic                frame_start
);

  localparam int unsigned          IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [BRIGHT_W-1:0]  BR_MAX   = '1;
  localparam logic [7:0]           SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [N-1:0]         AN_INV   = (AN_ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
  localparam logic [IW-1:0]        LAST_IDX = IW'(N - 1);

  if (GUARD_CYCLES == 0) begin : g_bad_guard
    $error("GUARD_CYCLES must be at least 1");
  end

  logic [IW-1:0]       r_digit_index;
  logic [BRIGHT_W-1:0] r_slot_cnt;
  logic [BRIGHT_W-1:0] r_bright_q;

  logic                w_slot_end;
  logic                w_guard_busy;
  logic [BRIGHT_W-1:0] w_bright_eff;
  logic                w_lit;
  logic [7:0]          w_seg_log;
  logic [N-1:0]        w_an_log;

  // At slot_cnt 0 the value being latched is the one in force for this slot.
  assign w_slot_end   = en && (r_slot_cnt == BR_MAX);
  assign w_bright_eff = (r_slot_cnt == '0) ? brightness : r_bright_q;
  assign w_lit        = !blank[r_digit_index] && !w_guard_busy &&
                        ((w_bright_eff == BR_MAX) || (r_slot_cnt < w_bright_eff));
  assign w_seg_log    = w_lit ? digit_values[r_digit_index] : 8'h00;
  assign w_an_log     = w_lit ? (N'(1) << r_digit_index) : '0;

  // Scan state, brightness latch and registered physical outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digit_index <= '0;
      r_slot_cnt    <= '0;
      r_bright_q    <= '0;
      seg_out       <= SEG_INV;
      an            <= AN_INV;
      frame_start   <= 1'b0;
    end else begin
      if (r_slot_cnt == '0) begin
        r_bright_q <= brightness;
      end
      if (en) begin
        r_slot_cnt <= r_slot_cnt + BRIGHT_W'(1);
        if (r_slot_cnt == BR_MAX) begin
          r_digit_index <= (r_digit_index == LAST_IDX) ? '0 : r_digit_index + IW'(1);
        end
      end
      frame_start <= w_slot_end && (r_digit_index == LAST_IDX);
      seg_out     <= w_seg_log ^ SEG_INV;
      an          <= w_an_log ^ AN_INV;
    end
  end

`ifdef SEVENSEG_GHOST_GUARD_EN
  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);

  logic [GW-1:0] r_guard;

  // Dark interval after every digit advance so slow anode drivers can settle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_guard <= '0;
    end else if (w_slot_end) begin
      r_guard <= GW'(GUARD_CYCLES);
    end else if (r_guard != '0) begin
      r_guard <= r_guard - GW'(1);
    end
  end

  assign w_guard_busy = (r_guard != '0);
`else
  assign w_guard_busy = 1'b0;
`endif

endmodule

// File: tb/tb_sevenseg_scan_pwm.sv
// Bench for sevenseg_scan_pwm: per-cycle reference model feeding a scoreboard, frame-level
// vector table, and hand sequences for reset, brightness change, polarity and mid-slot reset.
module tb_sevenseg_scan_pwm;
  localparam int unsigned N = 4;

  logic             clk;
  logic             reset_n;
  logic             en;
  logic [7:0]       dv [0:N-1];
  logic [N-1:0]     blank;
  logic [3:0]       bright;
  logic [7:0]       seg_a, seg_b;
  logic [N-1:0]     an_a, an_b;
  logic             fs_a, fs_b;

  int checks;
  int failures;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       fs;
  } exp_t;

  typedef struct {
    logic [3:0] bright;
    logic [3:0] blank;
    int         exp_lit [4];
    int         exp_fs;
  } vec_t;

  exp_t sb_q [$];
  vec_t vecs [7];

  int         m_idx;
  int         m_slot;
  int         m_guard;
  logic [3:0] m_bq;

  sevenseg_scan_pwm #(.N(N), .BRIGHT_W(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .GUARD_CYCLES(8)) u_dut_low (
    .clk(clk), .reset_n(reset_n), .en(en), .digit_values(dv), .blank(blank),
    .brightness(bright), .seg_out(seg_a), .an(an_a), .frame_start(fs_a)
  );

  sevenseg_scan_pwm #(.N(N), .BRIGHT_W(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0), .GUARD_CYCLES(8)) u_dut_high (
    .clk(clk), .reset_n(reset_n), .en(en), .digit_values(dv), .blank(blank),
    .brightness(bright), .seg_out(seg_b), .an(an_b), .frame_start(fs_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lit ticks per 16-tick slot for a given brightness.
  function automatic int exp_lit_cnt(input logic [3:0] b, input logic blk);
    if (blk) return 0;
`ifdef SEVENSEG_GHOST_GUARD_EN
    if (b == 4'hF) return 8;
    return (int'(b) > 8) ? int'(b) - 8 : 0;
`else
    if (b == 4'hF) return 16;
    return int'(b);
`endif
  endfunction

  // Reference model evaluated at each rising edge; queues the output the DUT should show next.
  task automatic model_edge();
    exp_t       e;
    logic       lit;
    logic [3:0] beff;
    e = '0;
    if (!reset_n) begin
      m_idx = 0; m_slot = 0; m_bq = 4'h0; m_guard = 0;
    end else begin
      beff = (m_slot == 0) ? bright : m_bq;
      lit  = !blank[m_idx] && ((beff == 4'hF) || (m_slot < int'(beff)));
`ifdef SEVENSEG_GHOST_GUARD_EN
      if (m_guard != 0) lit = 1'b0;
`endif
      e.seg = lit ? dv[m_idx] : 8'h00;
      e.an  = lit ? 4'(1 << m_idx) : 4'h0;
      e.fs  = en && (m_slot == 15) && (m_idx == N - 1);
      if (m_slot == 0) m_bq = bright;
      if (en && m_slot == 15) m_guard = 8;
      else if (m_guard > 0) m_guard--;
      if (en) begin
        if (m_slot == 15) begin
          m_slot = 0;
          m_idx  = (m_idx + 1) % N;
        end else begin
          m_slot++;
        end
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t        e;
    logic [12:0] act_a, exp_a, act_b, exp_b;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (!reset_n) e = '0;
      exp_a = {~e.seg, ~e.an, e.fs};
      exp_b = {e.seg, e.an, e.fs};
      act_a = {seg_a, an_a, fs_a};
      act_b = {seg_b, an_b, fs_b};
      check("scoreboard_active_low", 32'(act_a), 32'(exp_a));
      check("scoreboard_active_high", 32'(act_b), 32'(exp_b));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    sb_compare();
  endtask

  task automatic wait_frame();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (fs_a) found = 1'b1;
    end
    check("frame_wait", 32'(found), 32'd1);
  endtask

  initial begin
    logic [3:0] tb_b   [7];
    logic [3:0] tb_blk [7];
    int         cnt [4];
    int         fcnt;
    logic [3:0] oh;

    checks = 0; failures = 0;
    m_idx = 0; m_slot = 0; m_guard = 0; m_bq = 4'h0;
    tb_b   = '{4'hF, 4'd5, 4'd0, 4'hF, 4'd12, 4'd1, 4'd8};
    tb_blk = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1001, 4'b0000, 4'b0010};
    for (int i = 0; i < 7; i++) begin
      vecs[i].bright = tb_b[i];
      vecs[i].blank  = tb_blk[i];
      for (int d = 0; d < 4; d++) vecs[i].exp_lit[d] = exp_lit_cnt(tb_b[i], tb_blk[i][d]);
      vecs[i].exp_fs = 1;
    end

    reset_n = 1'b0; en = 1'b0; bright = 4'hF; blank = '0;
    dv = '{8'h3F, 8'h06, 8'h5B, 8'h4F};

    // Reset held with en toggling: outputs stay inactive.
    for (int i = 0; i < 6; i++) begin
      en = ~en;
      step();
      check("reset_seg_low", 32'(seg_a), 32'hFF);
      check("reset_an_low", 32'(an_a), 32'hF);
      check("reset_fs", 32'(fs_a), 32'd0);
      check("reset_high_outs", 32'({seg_b, an_b}), 32'd0);
    end

    reset_n = 1'b1; en = 1'b1;
    step();
    check("release_first_an", 32'(an_a), 32'b1110);
    check("release_first_seg", 32'(seg_a), 32'hC0);

    // Frame-level vectors: lit ticks per digit and one frame strobe per 64 ticks.
    for (int v = 0; v < 7; v++) begin
      bright = vecs[v].bright;
      blank  = vecs[v].blank;
      wait_frame();
      for (int d = 0; d < 4; d++) cnt[d] = 0;
      fcnt = 0;
      for (int i = 0; i < 64; i++) begin
        step();
        for (int d = 0; d < 4; d++) begin
          oh = 4'b0001 << d;
          if (an_a == ~oh) cnt[d]++;
        end
        if (fs_a) fcnt++;
      end
      for (int d = 0; d < 4; d++)
        check($sformatf("vec%0d_digit%0d_lit", v, d), 32'(cnt[d]), 32'(vecs[v].exp_lit[d]));
      check($sformatf("vec%0d_frame_pulses", v), 32'(fcnt), 32'(vecs[v].exp_fs));
    end

    // Brightness change mid-slot: digit 0 keeps 5, digit 1 uses 12.
    bright = 4'd5; blank = '0;
    wait_frame();
    cnt[0] = 0; cnt[1] = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (i == 2) bright = 4'd12;
      if (i < 16 && an_a == 4'b1110) cnt[0]++;
      if (i >= 16 && an_a == 4'b1101) cnt[1]++;
    end
    check("bright_hold_slot", 32'(cnt[0]), 32'(exp_lit_cnt(4'd5, 1'b0)));
    check("bright_next_slot", 32'(cnt[1]), 32'(exp_lit_cnt(4'd12, 1'b0)));

    // Decimal point only, both polarities.
    dv[0] = 8'h80; bright = 4'hF;
    wait_frame();
`ifdef SEVENSEG_GHOST_GUARD_EN
    repeat (8) step();
`endif
    step();
    check("dp_seg_high", 32'(seg_b), 32'h80);
    check("dp_an_high", 32'(an_b), 32'b0001);
    check("dp_seg_low", 32'(seg_a), 32'h7F);
    check("dp_an_low", 32'(an_a), 32'b1110);

    // Reset mid-slot: immediate inactive outputs, restart at digit 0.
    dv[0] = 8'h3F;
    wait_frame();
    repeat (21) step();
    reset_n = 1'b0;
    #1;
    check("midreset_low", 32'({seg_a, an_a, fs_a}), 32'({8'hFF, 4'hF, 1'b0}));
    check("midreset_high", 32'({seg_b, an_b, fs_b}), 32'd0);
    repeat (3) step();
    reset_n = 1'b1;
    step();
    check("midreset_restart_an_low", 32'(an_a), 32'b1110);
    check("midreset_restart_an_high", 32'(an_b), 32'b0001);

    // Sparse, irregular ticks with changing inputs, checked by the scoreboard.
    for (int i = 0; i < 600; i++) begin
      en = 1'($urandom_range(0, 1));
      if (i % 60 == 0) begin
        for (int d = 0; d < 4; d++) dv[d] = 8'($urandom_range(0, 255));
        blank  = 4'($urandom_range(0, 15));
        bright = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan_pwm.md
Name: sevenseg_scan_pwm

Overview:
- Parametrised multi-digit seven-segment scanner; successor to the basic digit multiplexer.
- Adds the following:
  - decimal point per digit
  - configurable segment and anode polarity
  - per-digit blanking
  - PWM brightness control
  - frame-start strobe
  - optional anti-ghosting guard interval
- Sits between the memory-mapped display register block (io_dev) and the board's segment/anode pins.
- Scan rate is set by an external tick (en).

Parameters:
- N, 4: number of digits (1..16).
- BRIGHT_W, 4: brightness and slot-counter width; a digit slot lasts 2^BRIGHT_W en ticks.
- SEG_ACTIVE_LOW, 1: 1 means seg_out is driven active-low (common anode); 0 means active-high.
- AN_ACTIVE_LOW, 1: 1 means an is driven active-low; 0 means active-high.
- GUARD_CYCLES, 8: clk cycles of forced blank after each digit change (used only with the optional feature; must be at least 1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  scan tick, one clk wide
- digit_values  in  [7:0] x N (unpacked [0:N-1])  per-digit pattern; bit7 = dp, bits6:0 = g..a; logical 1 = lit
- blank  in  N  per-digit blank mask; 1 forces that digit dark
- brightness  in  BRIGHT_W  duty value
- seg_out  out  8  physical segment drive (dp, g..a), polarity per SEG_ACTIVE_LOW
- an  out  N  physical digit enables, polarity per AN_ACTIVE_LOW
- frame_start  out  1  one-clk pulse when scanning wraps to digit 0

Behaviour:
- Index width: IW = max(1, $clog2(N)).
- State: digit_index (IW bits), slot_cnt (BRIGHT_W bits), bright_q (BRIGHT_W bits).
- Reset (asynchronous on reset_n low):
  - digit_index = 0, slot_cnt = 0, bright_q = 0, frame_start = 0.
  - seg_out and an at their inactive level: all-ones if active-low, all-zeros if active-high.
- Tick handling, on each clk with en = 1:
  - slot_cnt increments.
  - When slot_cnt = 2^BRIGHT_W - 1, it wraps to 0 and digit_index advances.
  - digit_index wraps from N-1 to 0 (values at or above N never occur).
  - With en = 0, all state holds.
- Brightness sampling:
  - bright_q <= brightness on every clk where slot_cnt == 0.
  - bright_q is frozen for the remainder of the slot, so a mid-slot brightness change takes effect at the next slot.
- Lit condition (internal, logical):
  - lit = !blank[digit_index] && (bright_q == all-ones || slot_cnt < bright_q).
  - bright_q = 0 means fully dark; all-ones means 100% duty; otherwise duty = bright_q / 2^BRIGHT_W.
- Outputs are registered; latency is 1 clk from any state or input change:
  - seg_log = lit ? digit_values[digit_index] : 8'h00.
  - an_log = lit ? one-hot(digit_index) : 0.
  - Physical outputs are the logical values, inverted when the corresponding *_ACTIVE_LOW = 1.
  - Exactly zero or one anode is active in any cycle.
  - blank and digit_values are sampled live, with no slot latch.
- frame_start:
  - Asserted for exactly 1 clk, in the cycle after the en tick that moves digit_index from N-1 to 0.
  - Not asserted out of reset.
- N = 1: digit_index stays 0, and frame_start pulses at every slot wrap.
- Reset mid-slot: outputs go inactive immediately. After release, scanning restarts at digit 0, slot_cnt 0.

Optional Feature:
- Macro: SEVENSEG_GHOST_GUARD_EN.
- Defined:
  - A guard counter loads GUARD_CYCLES on every digit_index change (including the N-1 -> 0 wrap).
  - It decrements each clk while nonzero, independent of en.
  - While it is nonzero, lit is forced to 0, so seg_out and an are inactive.
  - This suppresses ghosting from slow anode drivers.
  - The counter resets to 0.
  - If a new digit change occurs while it is nonzero, it reloads.
- Undefined:
  - No guard logic is present, and GUARD_CYCLES is ignored.
  - Digits switch back to back with 1 clk latency.

Test Plan:
1. Reset: hold reset_n = 0 with N=4 and active-low polarity, en toggling -> seg_out = 8'hFF, an = 4'hF, frame_start = 0 throughout. Release; with brightness = 4'hF, the first lit output appears 1 clk later with an = 4'b1110.
2. Full scan: N=4, brightness = 4'hF, en every clk, digit_values = {8'h3F, 8'h06, 8'h5B, 8'h4F} -> each digit is active for 16 clk in order 0,1,2,3. seg_out equals the inverted value. frame_start pulses once every 64 clk.
3. PWM: brightness = 4'd5 -> digit lit for 5 of 16 slot ticks. brightness = 0 -> never lit. Changing brightness from 5 to 12 at slot_cnt = 3 -> current slot keeps 5, next slot uses 12.
4. Blank: blank = 4'b0100 -> during digit 2's slot, an = 4'hF and seg_out = 8'hFF. Other digits are unaffected and slot timing is unchanged.
5. Polarity and dp: SEG_ACTIVE_LOW = 0, AN_ACTIVE_LOW = 0, digit_values[0] = 8'h80 -> seg_out = 8'h80 and an = 4'b0001 while digit 0 is lit. During reset, both outputs are 0.
6. Guard (SEVENSEG_GHOST_GUARD_EN, GUARD_CYCLES = 8, en every clk) -> after each digit change, 8 clk with an inactive, then 8 lit clk. Asserting reset_n mid-guard clears outputs and guard immediately.
